sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-requester round-robin controller in front of the 1024x8 asynchronous SRAM (ports: en, RWS, data_in, addr, OUT; RWS=1 write, RWS=0 read).
- Accepts one transaction at a time via valid/ready and drives en/RWS/addr/data_in with stable timing.
- Captures read data and returns a one-cycle response pulse to the granted requester.
- Sits between the CPU-side and DMA-side masters and the SRAM instance.

Parameters:
- ADDR_W, 10, SRAM address width (1024 words).
- DATA_W, 8, SRAM data width.
- ACC_CYC, 2, cycles en is held in ACCESS; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- reqN_valid  in  1  request from port N; N = 0, 1.
- reqN_ready  out  1  port N request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  word address.
- reqN_wdata  in  DATA_W  write data.
- rspN_valid  out  1  one-cycle completion pulse, for writes and reads.
- rspN_rdata  out  DATA_W  read data; holds its value until the next read completes on that port.
- sram_en  out  1  to SRAM en.
- sram_rws  out  1  to SRAM RWS.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_din  out  DATA_W  to SRAM data_in.
- sram_dout  in  DATA_W  from SRAM OUT.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - state=IDLE, rr pointer favours port 0.
  - sram_en=0, sram_rws=0, sram_addr=0, sram_din=0.
  - All ready and rsp_valid outputs = 0, rspN_rdata=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted port when state=IDLE and that port's valid is high.
  - Grant rule: if one port is valid, grant it. If both are valid, grant the port the rr pointer favours; the pointer then favours the other port.
  - On valid&&ready, latch we/addr/wdata and the port ID, then go to ACCESS.
- ACCESS (ACC_CYC cycles):
  - sram_en=1, sram_rws=latched we, sram_addr/sram_din from latched values.
  - All SRAM outputs are registered and stable for the whole phase.
  - On the last ACCESS cycle: for a read, register sram_dout into the granted port's rdata.
  - Then go to RESP.
- RESP (1 cycle):
  - sram_en=0, sram_rws=0; sram_addr is held.
  - rsp_valid=1 for the granted port only. Return to IDLE.
- Latency: accept at cycle T; ACCESS T+1..T+ACC_CYC; rsp_valid at T+ACC_CYC+1. Back-to-back throughput is one transaction per ACC_CYC+2 cycles.
- sram_rws is never 1 while sram_en=0, so no spurious writes.
- No ready is asserted outside IDLE; requesters hold valid and payload until ready.
- Address 1023 is legal; no wrap or check.
- A requester deasserting valid before ready: no transaction, no side effects.
- Reset during ACCESS or RESP: the transaction is aborted, no rsp pulse, sram_en=0 the next cycle.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1, 16 bits each.
  - Each counts accepted transactions per port, saturating at 16'hFFFF, cleared by rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum (IDLE, ACCESS, RESP).
  - Transaction struct (we, addr, wdata, port ID).
- Sub-module rr_arbiter2:
  - Two-input round-robin grant with pointer register.
  - Advances only on an accept strobe.

Test Plan:
- Port0 write addr=10 data=100, then read addr=10 -> rsp0_valid at T+3 (ACC_CYC=2), rsp0_rdata=100; sram_en high exactly 2 cycles per transaction.
- Port1 write addr=20 data=200 and port0 write addr=1000 data=5 in the same cycle -> port0 granted first, port1 next.
  - Read-backs return 200 and 5.
  - Grant order alternates over 4 simultaneous rounds.
- Boundary: write addr=1023 data=255, read addr=1023 -> 255.
  - Write addr=0 data=1, read addr=0 -> 1.
- Reset asserted in the 2nd ACCESS cycle of a write addr=40 data=150.
  - sram_en=0 the next cycle, no rsp_valid.
  - All outputs at reset values.
- Port1 holds valid through port0's transaction -> no ready to port1 until IDLE; rsp_valid never asserted on both ports simultaneously.
- With SRAM_ARB_STATS_EN: 3 port0 + 2 port1 transactions -> stat_grant0=3, stat_grant1=2; rst clears both to 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: default widths, controller states and the
// latched transaction record.
package sram_arb_pkg;

   localparam int ARB_ADDR_W = 10;
   localparam int ARB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic                  port;
   } txn_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-input round-robin grant. The pointer only moves when both inputs contend
// and the grant is actually taken, so an uncontended port never loses its turn.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic accept_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt0_o = req0_i & (~req1_i | ~ptr_q);
      gnt1_o = req1_i & (~req0_i | ptr_q);
      ptr_d  = ptr_q;
      if (accept_i && req0_i && req1_i) ptr_d = ~ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin front end for a 1024x8 asynchronous SRAM.
// Optional per-port grant counters are enabled with SRAM_ARB_STATS_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int ACC_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              sram_en,
   output logic              sram_rws,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_grant0,
   output logic [15:0]       stat_grant1
`endif
);

   localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   txn_t              txn_q, txn_d;
   logic              en_q, en_d;
   logic              rws_q, rws_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              gnt0, gnt1, accept, last_acc;

   assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);
   assign last_acc = (cnt_q == CNT_W'(ACC_CYC - 1));

   rr_arbiter2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .req0_i   (req0_valid),
      .req1_i   (req1_valid),
      .accept_i (accept),
      .gnt0_o   (gnt0),
      .gnt1_o   (gnt1)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      txn_d    = txn_q;
      en_d     = en_q;
      rws_d    = rws_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               txn_d.we    = gnt1 ? req1_we    : req0_we;
               txn_d.addr  = gnt1 ? req1_addr  : req0_addr;
               txn_d.wdata = gnt1 ? req1_wdata : req0_wdata;
               txn_d.port  = gnt1;
               en_d        = 1'b1;
               rws_d       = gnt1 ? req1_we : req0_we;
               cnt_d       = '0;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // Address is registered and stable, so OUT has settled by the last cycle.
            if (last_acc) begin
               en_d    = 1'b0;
               rws_d   = 1'b0;
               state_d = RESP;
               if (!txn_q.we) begin
                  if (txn_q.port) rdata1_d = sram_dout;
                  else            rdata0_d = sram_dout;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         txn_q    <= '0;
         en_q     <= 1'b0;
         rws_q    <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         txn_q    <= txn_d;
         en_q     <= en_d;
         rws_q    <= rws_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign req0_ready = (state_q == IDLE) && gnt0;
   assign req1_ready = (state_q == IDLE) && gnt1;
   assign rsp0_valid = (state_q == RESP) && !txn_q.port;
   assign rsp1_valid = (state_q == RESP) &&  txn_q.port;
   assign rsp0_rdata = rdata0_q;
   assign rsp1_rdata = rdata1_q;
   assign sram_en    = en_q;
   assign sram_rws   = rws_q;
   assign sram_addr  = txn_q.addr;
   assign sram_din   = txn_q.wdata;

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] stat0_q, stat1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat0_q <= '0;
         stat1_q <= '0;
      end else begin
         if (req0_valid && req0_ready && stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
         if (req1_valid && req1_ready && stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
      end
   end

   assign stat_grant0 = stat0_q;
   assign stat_grant1 = stat1_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM, directed scenarios and random
// traffic checked against a memory/round-robin reference model.
module tb_sram_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 8;
   localparam int ACC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;
   logic          sram_en, sram_rws;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0]   stat_grant0, stat_grant1;
`endif

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(ACC)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .sram_en    (sram_en),
      .sram_rws   (sram_rws),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
`ifdef SRAM_ARB_STATS_EN
      ,
      .stat_grant0 (stat_grant0),
      .stat_grant1 (stat_grant1)
`endif
   );

   // Async SRAM: unwritten words read back a fixed address-derived pattern.
   logic [DW-1:0] mem [1024];
   logic          written [1024];

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a) ^ 8'h5A;
   endfunction

   assign sram_dout = written[sram_addr] ? mem[sram_addr] : init_val(int'(sram_addr));

   always @(posedge clk) begin
      if (sram_en && sram_rws) begin
         mem[sram_addr]     <= sram_din;
         written[sram_addr] <= 1'b1;
      end
   end

   // Reference model state
   int      checks = 0;
   int      errors = 0;
   logic [DW-1:0] ref_mem [1024];
   int      ptr_m;
   int      cnt_m [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stats();
`ifdef SRAM_ARB_STATS_EN
      chk("stat_grant0", 32'(stat_grant0), 32'(cnt_m[0]));
      chk("stat_grant1", 32'(stat_grant1), 32'(cnt_m[1]));
`endif
   endtask

   task automatic run_pair(input logic v0, input logic we0, input int a0, input int d0,
                           input logic v1, input logic we1, input int a1, input int d1);
      int order [2];
      int n, first_seen, got, en_cnt, busy;
      int acc_c [2];
      int rsp_c [2];
      int exp_rd [2];
      logic a0now, a1now;
      n = 0;
      if (v0 && v1) begin
         order[0] = ptr_m; order[1] = 1 - ptr_m; n = 2;
         ptr_m = 1 - ptr_m;
      end else begin
         order[0] = v0 ? 0 : 1; n = 1;
      end
      for (int i = 0; i < n; i++) begin
         if (order[i] == 0) begin
            if (we0) ref_mem[a0] = DW'(d0); else exp_rd[0] = int'(ref_mem[a0]);
         end else begin
            if (we1) ref_mem[a1] = DW'(d1); else exp_rd[1] = int'(ref_mem[a1]);
         end
         cnt_m[order[i]]++;
      end
      req0_valid = v0; req0_we = we0; req0_addr = AW'(a0); req0_wdata = DW'(d0);
      req1_valid = v1; req1_we = we1; req1_addr = AW'(a1); req1_wdata = DW'(d1);
      first_seen = -1; got = 0; en_cnt = 0;
      acc_c[0] = -1; acc_c[1] = -1; rsp_c[0] = -1; rsp_c[1] = -1;
      for (int cyc = 1; cyc <= 40 && got < n; cyc++) begin
         @(negedge clk);
         a0now = req0_valid & req0_ready;
         a1now = req1_valid & req1_ready;
         busy  = ((acc_c[0] >= 0 && rsp_c[0] < 0) || (acc_c[1] >= 0 && rsp_c[1] < 0)) ? 1 : 0;
         chk("ready_while_busy", 32'(busy != 0 && (req0_ready || req1_ready)), 32'd0);
         chk("rws_without_en", 32'(sram_rws & ~sram_en), 32'd0);
         chk("rsp_both_ports", 32'(rsp0_valid & rsp1_valid), 32'd0);
         if (sram_en) en_cnt++;
         if (a0now) begin acc_c[0] = cyc; if (first_seen < 0) first_seen = 0; end
         if (a1now) begin acc_c[1] = cyc; if (first_seen < 0) first_seen = 1; end
         if (rsp0_valid) begin rsp_c[0] = cyc; got++; end
         if (rsp1_valid) begin rsp_c[1] = cyc; got++; end
         @(posedge clk); #1;
         if (a0now) req0_valid = 1'b0;
         if (a1now) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("responses_seen", 32'(got), 32'(n));
      if (n == 2) chk("first_grant", 32'(first_seen), 32'(order[0]));
      chk("en_cycles", 32'(en_cnt), 32'(ACC * n));
      if (v0) begin
         chk("latency0", 32'(rsp_c[0] - acc_c[0]), 32'(ACC + 1));
         if (!we0) chk("rdata0", 32'(rsp0_rdata), 32'(exp_rd[0]));
      end
      if (v1) begin
         chk("latency1", 32'(rsp_c[1] - acc_c[1]), 32'(ACC + 1));
         if (!we1) chk("rdata1", 32'(rsp1_rdata), 32'(exp_rd[1]));
      end
      chk_stats();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_en"},    32'(sram_en), 32'd0);
      chk({tag, "_rws"},   32'(sram_rws), 32'd0);
      chk({tag, "_addr"},  32'(sram_addr), 32'd0);
      chk({tag, "_din"},   32'(sram_din), 32'd0);
      chk({tag, "_rdy"},   32'({req0_ready, req1_ready}), 32'd0);
      chk({tag, "_rsp"},   32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk({tag, "_rd0"},   32'(rsp0_rdata), 32'd0);
      chk({tag, "_rd1"},   32'(rsp1_rdata), 32'd0);
   endtask

   initial begin
      int t;
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = init_val(i);
         written[i] = 1'b0;
      end
      ptr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
      rst = 1'b1;
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk_stats();
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic write then read on port 0
      run_pair(1, 1, 10, 100, 0, 0, 0, 0);
      run_pair(1, 0, 10, 0,   0, 0, 0, 0);
      chk("readback_10", 32'(rsp0_rdata), 32'd100);

      // Contention: four simultaneous rounds must alternate
      run_pair(1, 1, 1000, 5, 1, 1, 20, 200);
      run_pair(1, 0, 1000, 0, 1, 0, 20, 0);
      chk("readback_20", 32'(rsp1_rdata), 32'd200);
      chk("readback_1000", 32'(rsp0_rdata), 32'd5);
      run_pair(1, 1, 30, 7, 1, 1, 31, 9);
      run_pair(1, 0, 31, 0, 1, 0, 30, 0);

      // Address boundaries
      run_pair(1, 1, 1023, 255, 0, 0, 0, 0);
      run_pair(0, 0, 0, 0, 1, 0, 1023, 0);
      chk("readback_1023", 32'(rsp1_rdata), 32'd255);
      run_pair(0, 0, 0, 0, 1, 1, 0, 1);
      run_pair(1, 0, 0, 0, 0, 0, 0, 0);
      chk("readback_0", 32'(rsp0_rdata), 32'd1);

      // Reset in the second ACCESS cycle of a write
      req0_valid = 1; req0_we = 1; req0_addr = AW'(40); req0_wdata = DW'(150);
      t = 0;
      for (int c = 0; c < 10 && t == 0; c++) begin
         @(negedge clk);
         if (req0_ready) t = 1;
         @(posedge clk); #1;
      end
      req0_valid = 0;
      chk("abort_accepted", 32'(t), 32'd1);
      @(negedge clk);
      chk("abort_acc1_en", 32'(sram_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_acc2_en", 32'(sram_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("abort");
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      @(posedge clk); #1;
      // The SRAM saw en/RWS with this data before the abort took effect.
      ref_mem[40] = 8'd150;
      ptr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
      chk_stats();

      // Three port-0 and two port-1 transactions after reset
      run_pair(1, 1, 50, 11, 1, 1, 51, 22);
      run_pair(1, 0, 50, 0,  1, 0, 51, 0);
      run_pair(1, 0, 40, 0,  0, 0, 0, 0);
      chk("readback_40", 32'(rsp0_rdata), 32'd150);

      // Random traffic
      for (int r = 0; r < 40; r++) begin
         logic v0, v1, w0, w1;
         int x0, x1;
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         x0 = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 63));
         x1 = ($urandom_range(0, 7) == 0) ? 0    : int'($urandom_range(0, 63));
         run_pair(v0, w0, x0, int'($urandom_range(0, 255)),
                  v1, w1, x1, int'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
